psum_adder_ctrl: RTL and testbench
==================================

PSUM_ADDER_CTRL -- requirements
Module: psum_adder_ctrl

Interface
REQ-001 SHALL have parameter PSUM_IN_WIDTH, default 1280, width of one psum vector (256 x 5-bit lanes).
REQ-002 SHALL have parameter OFMAPS_BRAM_ADDR_WIDTH, default 12, width of the ofmap BRAM address.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle layer start request.
REQ-006 SHALL have port cfg_in_channel  input  12  input channel count for the layer.
REQ-007 SHALL have port cfg_kernel_size  input  5  one-hot kernel size (bit4=5x5 ... bit0=1x1).
REQ-008 SHALL have port cfg_out_count  input  OFMAPS_BRAM_ADDR_WIDTH+1  number of output pixels, 1..2^OFMAPS_BRAM_ADDR_WIDTH.
REQ-009 SHALL have port cfg_base_addr  input  OFMAPS_BRAM_ADDR_WIDTH  first ofmap address.
REQ-010 SHALL have ports s_psum (input, PSUM_IN_WIDTH), s_valid (input, 1) and s_ready (output, 1): upstream psum stream.
REQ-011 SHALL have ports a_psum (output, PSUM_IN_WIDTH), a_address (output, OFMAPS_BRAM_ADDR_WIDTH), a_valid (output, 1) and a_layer_finish (output, 1): drive to adder.
REQ-012 SHALL have ports a_in_channel (output, 12) and a_kernel_size (output, 5): latched config to adder.
REQ-013 SHALL have ports a_o_valid (input, 1) and a_o_last (input, 1): adder result-valid and last returns.
REQ-014 SHALL have status outputs busy (1), done (1, one-cycle pulse), err_cfg (1, sticky) and err_drain (1, sticky).

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
REQ-016 In IDLE, start SHALL be accepted only with a valid config: cfg_out_count != 0, cfg_in_channel != 0, cfg_kernel_size exactly one-hot.
REQ-017 On a valid start, the block SHALL latch all cfg_* inputs, clear issue/return counters and both error flags, and enter RUN.
REQ-018 On an invalid start, the block SHALL set err_cfg=1 and remain in IDLE.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 s_ready SHALL equal (state==RUN), with no dependency on s_valid.
REQ-021 Each s_valid&&s_ready beat SHALL be registered, with a_valid=1, a_psum=s_psum and a_address=base+issue_cnt (mod 2^OFMAPS_BRAM_ADDR_WIDTH) presented on the next cycle only.
REQ-022 a_valid SHALL be 0 in every other cycle; a_psum and a_address SHALL hold their values when idle.
REQ-023 a_layer_finish SHALL be 1 exactly in the cycle the last beat (issue_cnt==out_count-1) is presented; the FSM SHALL enter DRAIN in that cycle.
REQ-024 a_in_channel and a_kernel_size SHALL drive the latched values, stable from RUN entry until the next accepted start.
REQ-025 In RUN and DRAIN, ret_cnt SHALL increment on each a_o_valid.
REQ-026 a_o_last in DRAIN SHALL move the FSM to DONE; if ret_cnt (including any same-cycle a_o_valid) != out_count, err_drain SHALL be set to 1.
REQ-027 a_o_valid or a_o_last in IDLE/DONE SHALL set err_drain and otherwise be ignored.
REQ-028 DONE SHALL last one cycle with done=1, then the FSM SHALL return to IDLE.
REQ-029 busy SHALL be 1 in RUN, DRAIN and DONE.
REQ-030 Back-pressure-free upstream SHALL sustain one beat per cycle; gaps in s_valid SHALL insert a_valid bubbles without changing address order.
REQ-031 Address wrap SHALL be modular: with base=0xFFE and count=4, addresses SHALL be FFE, FFF, 000, 001.

Reset
REQ-032 While rst=1, state SHALL be IDLE, and all counters, a_valid, a_layer_finish, s_ready, busy, done, err_cfg, err_drain, a_psum, a_address, a_in_channel and a_kernel_size SHALL be 0.
REQ-033 Reset mid-RUN/DRAIN SHALL abort the layer with no done pulse; late adder returns after reset SHALL set err_drain per REQ-027.

Structure
REQ-034 Shared package psum_ctrl_pkg SHALL hold the FSM state encoding, the kernel one-hot constants (K1..K5) and the default adder latency constant (10).
REQ-035 The block SHALL contain no sub-module; psum_adder is instantiated beside it at the parent level.

Verification
REQ-036 start with cfg count=3, base=0x010, in_ch=4, k=3x3, then 3 back-to-back beats -> a_address 010, 011, 012 on consecutive cycles, a_layer_finish with 012, done 11 cycles after the last a_valid when a real adder is attached.
REQ-037 start with kernel_size=5'b00110 -> err_cfg=1, busy stays 0, s_ready stays 0.
REQ-038 base=0xFFE, count=4, s_valid toggling 1,0,1,0 -> a_address FFE, FFF, 000, 001 with bubbles, order preserved.
REQ-039 count=2 with adder model returning only one a_o_valid then a_o_last -> done pulse and err_drain=1.
REQ-040 rst asserted two cycles into RUN -> all outputs 0 immediately, no done; a new start afterwards is accepted normally.
REQ-041 start pulsed again during DRAIN -> ignored, with latched cfg and addresses unchanged.

Source files
------------

// File: rtl/psum_ctrl_pkg.sv
// psum_ctrl_pkg: shared FSM encoding, kernel one-hot codes and adder latency for the psum controller.
package psum_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;
  localparam logic [4:0] K1 = 5'b00001;
  localparam logic [4:0] K2 = 5'b00010;
  localparam logic [4:0] K3 = 5'b00100;
  localparam logic [4:0] K4 = 5'b01000;
  localparam logic [4:0] K5 = 5'b10000;
  localparam int ADDER_LATENCY = 10;
  function automatic logic kernel_ok(input logic [4:0] k);
    return k == K1 || k == K2 || k == K3 || k == K4 || k == K5;
  endfunction
endpackage

// File: rtl/psum_adder_ctrl.sv
// psum_adder_ctrl: sequences one layer of psum beats into the adder and tracks its result returns.
module psum_adder_ctrl
  import psum_ctrl_pkg::*;
#(
  parameter int PSUM_IN_WIDTH = 1280,
  parameter int OFMAPS_BRAM_ADDR_WIDTH = 12
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [11:0]                       cfg_in_channel,
  input  logic [4:0]                        cfg_kernel_size,
  input  logic [OFMAPS_BRAM_ADDR_WIDTH:0]   cfg_out_count,
  input  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [PSUM_IN_WIDTH-1:0]          s_psum,
  input  logic                              s_valid,
  output logic                              s_ready,
  output logic [PSUM_IN_WIDTH-1:0]          a_psum,
  output logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] a_address,
  output logic                              a_valid,
  output logic                              a_layer_finish,
  output logic [11:0]                       a_in_channel,
  output logic [4:0]                        a_kernel_size,
  input  logic                              a_o_valid,
  input  logic                              a_o_last,
  output logic                              busy,
  output logic                              done,
  output logic                              err_cfg,
  output logic                              err_drain
);
  localparam int AW = OFMAPS_BRAM_ADDR_WIDTH;
  state_t state, state_nx;
  logic [AW:0] out_count_q, issue_cnt, ret_cnt, ret_nx;
  logic [AW-1:0] base_q;
  logic cfg_ok, beat, last_beat, stray, draining;
  assign cfg_ok = cfg_out_count != '0 && cfg_in_channel != '0 && kernel_ok(cfg_kernel_size);
  assign s_ready = state == ST_RUN;
  assign busy = state != ST_IDLE;
  assign done = state == ST_DONE;
  assign beat = s_valid && s_ready;
  assign last_beat = beat && issue_cnt == out_count_q - 1'b1;
  assign draining = state == ST_RUN || state == ST_DRAIN;
  assign stray = (state == ST_IDLE || state == ST_DONE) && (a_o_valid || a_o_last);
  assign ret_nx = ret_cnt + (AW+1)'(a_o_valid);
  always_comb begin
    state_nx = state;
    state_nx = state == ST_IDLE  ? (start && cfg_ok ? ST_RUN : ST_IDLE) :
               state == ST_RUN   ? (last_beat ? ST_DRAIN : ST_RUN) :
               state == ST_DRAIN ? (a_o_last ? ST_DONE : ST_DRAIN) : ST_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_count_q <= '0;
      issue_cnt <= '0;
      ret_cnt <= '0;
      base_q <= '0;
      a_psum <= '0;
      a_address <= '0;
      a_valid <= 1'b0;
      a_layer_finish <= 1'b0;
      a_in_channel <= '0;
      a_kernel_size <= '0;
      err_cfg <= 1'b0;
      err_drain <= 1'b0;
    end else begin
      a_valid <= beat;
      a_layer_finish <= last_beat;
      if (beat) begin
        a_psum <= s_psum;
        a_address <= base_q + issue_cnt[AW-1:0];
        issue_cnt <= issue_cnt + 1'b1;
      end
      if (state == ST_IDLE && start) begin
        if (cfg_ok) begin
          out_count_q <= cfg_out_count;
          base_q <= cfg_base_addr;
          a_in_channel <= cfg_in_channel;
          a_kernel_size <= cfg_kernel_size;
          issue_cnt <= '0;
          ret_cnt <= '0;
          err_cfg <= 1'b0;
          err_drain <= 1'b0;
        end else err_cfg <= 1'b1;
      end
      if (draining && a_o_valid) ret_cnt <= ret_nx;
      // A short or over-long return count is only judged when the adder signals last.
      if (state == ST_DRAIN && a_o_last && ret_nx != out_count_q) err_drain <= 1'b1;
      if (stray) err_drain <= 1'b1;
    end
  end
endmodule

// File: tb/tb_psum_adder_ctrl.sv
// tb_psum_adder_ctrl: directed self-checking bench for psum_adder_ctrl.
module tb_psum_adder_ctrl;
  import psum_ctrl_pkg::*;
  localparam int PW = 1280;
  localparam int AW = 12;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [11:0] cfg_in_channel = '0;
  logic [4:0] cfg_kernel_size = '0;
  logic [AW:0] cfg_out_count = '0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [PW-1:0] s_psum = '0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [PW-1:0] a_psum;
  logic [AW-1:0] a_address;
  logic a_valid, a_layer_finish;
  logic [11:0] a_in_channel;
  logic [4:0] a_kernel_size;
  logic a_o_valid = 1'b0;
  logic a_o_last = 1'b0;
  logic busy, done, err_cfg, err_drain;
  int total = 0;
  int bad = 0;
  logic [AW-1:0] wrap_addr [4];

  psum_adder_ctrl #(.PSUM_IN_WIDTH(PW), .OFMAPS_BRAM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_in_channel(cfg_in_channel), .cfg_kernel_size(cfg_kernel_size),
    .cfg_out_count(cfg_out_count), .cfg_base_addr(cfg_base_addr),
    .s_psum(s_psum), .s_valid(s_valid), .s_ready(s_ready),
    .a_psum(a_psum), .a_address(a_address), .a_valid(a_valid),
    .a_layer_finish(a_layer_finish), .a_in_channel(a_in_channel),
    .a_kernel_size(a_kernel_size), .a_o_valid(a_o_valid), .a_o_last(a_o_last),
    .busy(busy), .done(done), .err_cfg(err_cfg), .err_drain(err_drain)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [AW:0] cnt, input logic [AW-1:0] base, input logic [11:0] ch, input logic [4:0] k);
    cfg_out_count = cnt;
    cfg_base_addr = base;
    cfg_in_channel = ch;
    cfg_kernel_size = k;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d);
    s_valid = 1'b1;
    s_psum = {40{d}};
    step();
    s_valid = 1'b0;
  endtask

  initial begin
    wrap_addr[0] = 12'hFFE;
    wrap_addr[1] = 12'hFFF;
    wrap_addr[2] = 12'h000;
    wrap_addr[3] = 12'h001;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sready", 32'(s_ready), 32'd0);
    chk("rst_avalid", 32'(a_valid), 32'd0);
    chk("rst_addr", 32'(a_address), 32'd0);
    chk("rst_errs", {30'd0, err_cfg, err_drain}, 32'd0);
    chk("rst_cfgout", {15'd0, a_in_channel, a_kernel_size}, 32'd0);
    rst = 1'b0;
    step();

    // back-to-back layer, count 3 at base 0x010, 3x3 kernel
    cfg(13'd3, 12'h010, 12'd4, K3);
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_sready", 32'(s_ready), 32'd1);
    chk("run_inch", 32'(a_in_channel), 32'd4);
    chk("run_k", 32'(a_kernel_size), 32'h04);
    chk("idle_avalid", 32'(a_valid), 32'd0);
    s_valid = 1'b1;
    s_psum = {40{32'hA0A0_0001}};
    step();
    chk("b0_valid", 32'(a_valid), 32'd1);
    chk("b0_addr", 32'(a_address), 32'h010);
    chk("b0_psum", a_psum[31:0], 32'hA0A0_0001);
    chk("b0_fin", 32'(a_layer_finish), 32'd0);
    s_psum = {40{32'hA0A0_0002}};
    step();
    chk("b1_addr", 32'(a_address), 32'h011);
    chk("b1_psum_hi", a_psum[PW-1 -: 32], 32'hA0A0_0002);
    s_psum = {40{32'hA0A0_0003}};
    step();
    s_valid = 1'b0;
    chk("b2_valid", 32'(a_valid), 32'd1);
    chk("b2_addr", 32'(a_address), 32'h012);
    chk("b2_fin", 32'(a_layer_finish), 32'd1);
    chk("b2_sready", 32'(s_ready), 32'd0);
    step();
    chk("post_valid", 32'(a_valid), 32'd0);
    chk("post_fin", 32'(a_layer_finish), 32'd0);
    chk("post_addr_hold", 32'(a_address), 32'h012);
    repeat (ADDER_LATENCY - 3) step();
    a_o_valid = 1'b1;
    step();
    step();
    a_o_last = 1'b1;
    chk("no_early_done", 32'(done), 32'd0);
    step();
    a_o_valid = 1'b0;
    a_o_last = 1'b0;
    chk("l1_done", 32'(done), 32'd1);
    chk("l1_busy_done", 32'(busy), 32'd1);
    chk("l1_err_drain", 32'(err_drain), 32'd0);
    step();
    chk("l1_done_pulse", 32'(done), 32'd0);
    chk("l1_idle", 32'(busy), 32'd0);

    // non-one-hot kernel rejected
    cfg(13'd3, 12'h010, 12'd4, 5'b00110);
    chk("bad_k_err", 32'(err_cfg), 32'd1);
    chk("bad_k_busy", 32'(busy), 32'd0);
    chk("bad_k_sready", 32'(s_ready), 32'd0);
    cfg(13'd0, 12'h010, 12'd4, K1);
    chk("zero_cnt_busy", 32'(busy), 32'd0);
    cfg(13'd2, 12'h010, 12'd0, K1);
    chk("zero_ch_busy", 32'(busy), 32'd0);
    chk("err_cfg_sticky", 32'(err_cfg), 32'd1);

    // address wrap with alternating s_valid
    cfg(13'd4, 12'hFFE, 12'd1, K1);
    chk("wrap_err_cfg_clr", 32'(err_cfg), 32'd0);
    chk("wrap_k", 32'(a_kernel_size), 32'h01);
    for (int i = 0; i < 8; i++) begin
      s_valid = !i[0];
      s_psum = {40{32'(i)}};
      step();
      chk($sformatf("wrap_valid%0d", i), 32'(a_valid), 32'(!i[0]));
      chk($sformatf("wrap_addr%0d", i), 32'(a_address), 32'(wrap_addr[i / 2]));
      if (!i[0]) chk($sformatf("wrap_fin%0d", i), 32'(a_layer_finish), 32'(i == 6));
    end
    s_valid = 1'b0;
    chk("wrap_drain_sready", 32'(s_ready), 32'd0);
    a_o_valid = 1'b1;
    step();
    step();
    step();
    a_o_last = 1'b1;
    step();
    a_o_valid = 1'b0;
    a_o_last = 1'b0;
    chk("wrap_done", 32'(done), 32'd1);
    chk("wrap_err_drain", 32'(err_drain), 32'd0);
    step();

    // short return count flagged
    cfg(13'd2, 12'h100, 12'd3, K2);
    beat(32'h1);
    beat(32'h2);
    chk("short_fin", 32'(a_layer_finish), 32'd1);
    a_o_valid = 1'b1;
    step();
    a_o_valid = 1'b0;
    a_o_last = 1'b1;
    step();
    a_o_last = 1'b0;
    chk("short_done", 32'(done), 32'd1);
    chk("short_err", 32'(err_drain), 32'd1);
    step();
    chk("short_err_sticky", 32'(err_drain), 32'd1);
    chk("short_idle", 32'(busy), 32'd0);

    // start during DRAIN is ignored
    cfg(13'd2, 12'h020, 12'd7, K5);
    chk("drain_err_clr", 32'(err_drain), 32'd0);
    beat(32'h11);
    beat(32'h12);
    cfg(13'd5, 12'h300, 12'd9, K2);
    chk("ign_sready", 32'(s_ready), 32'd0);
    chk("ign_inch", 32'(a_in_channel), 32'd7);
    chk("ign_k", 32'(a_kernel_size), 32'h10);
    chk("ign_addr", 32'(a_address), 32'h021);
    chk("ign_busy", 32'(busy), 32'd1);
    a_o_valid = 1'b1;
    step();
    a_o_last = 1'b1;
    step();
    a_o_valid = 1'b0;
    a_o_last = 1'b0;
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_err", 32'(err_drain), 32'd0);
    step();

    // asynchronous reset mid-RUN
    cfg(13'd8, 12'h040, 12'd5, K3);
    s_valid = 1'b1;
    s_psum = {40{32'h55}};
    step();
    step();
    s_valid = 1'b0;
    chk("pre_rst_addr", 32'(a_address), 32'h041);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(a_valid), 32'd0);
    chk("arst_addr", 32'(a_address), 32'd0);
    chk("arst_psum", a_psum[31:0], 32'd0);
    chk("arst_cfgout", {15'd0, a_in_channel, a_kernel_size}, 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    step();
    rst = 1'b0;
    a_o_valid = 1'b1;
    step();
    a_o_valid = 1'b0;
    chk("late_ret_err", 32'(err_drain), 32'd1);
    chk("late_ret_no_done", 32'(done), 32'd0);
    cfg(13'd1, 12'h005, 12'd2, K4);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_err_clr", 32'(err_drain), 32'd0);
    beat(32'h77);
    chk("restart_addr", 32'(a_address), 32'h005);
    chk("restart_fin", 32'(a_layer_finish), 32'd1);
    a_o_valid = 1'b1;
    a_o_last = 1'b1;
    step();
    a_o_valid = 1'b0;
    a_o_last = 1'b0;
    chk("restart_done", 32'(done), 32'd1);
    chk("restart_err", 32'(err_drain), 32'd0);
    step();
    chk("final_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
